cpu_serial_port: RTL and testbench



---
 rtl/cpu_serial_port.sv | 156 +++++++++++++++
 tb/tb_cpu_serial_port.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_serial_port.sv
// Bus interface unit: serialises one core memory transaction onto tx_pins and
// deserialises the read response arriving on rx_pins.
module cpu_serial_port #(
    parameter int IO_BITS   = 2,
    parameter int DATA_BITS = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_write,
    input  logic                 req_fetch,
    input  logic [DATA_BITS-1:0] req_addr,
    input  logic [DATA_BITS-1:0] req_wdata,
    output logic                 rsp_valid,
    output logic [DATA_BITS-1:0] rsp_data,
    output logic                 wr_done,
    output logic [IO_BITS-1:0]   tx_pins,
    output logic                 tx_fetch,
    input  logic [IO_BITS-1:0]   rx_pins
);
    localparam int NCHUNK = DATA_BITS / IO_BITS;
    localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

    typedef enum logic [2:0] {IDLE, TX_START, TX_ADDR, TX_DATA, RX_WAIT, RX_DATA} state_t;

    state_t                state, state_n;
    logic [CW-1:0]         cnt, cnt_n;
    logic [DATA_BITS-1:0]  tx_sh, tx_sh_n;
    logic [DATA_BITS-1:0]  wdata_q, wdata_q_n;
    logic                  write_q, write_q_n;
    logic                  fetch_q, fetch_q_n;
    logic [DATA_BITS-1:0]  rx_sh, rx_sh_n;
    logic [DATA_BITS-1:0]  rsp_data_n;
    logic [IO_BITS-1:0]    tx_pins_n;
    logic                  tx_fetch_n, rsp_valid_n, wr_done_n;
    logic [DATA_BITS+IO_BITS-1:0] rx_cat;

    assign req_ready = (state == IDLE);
    assign rx_cat    = {rx_pins, rx_sh};

    // Output registers load from next-state values so each chunk appears
    // on the pins during the cycle its state is current.
    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        tx_sh_n     = tx_sh;
        wdata_q_n   = wdata_q;
        write_q_n   = write_q;
        fetch_q_n   = fetch_q;
        rx_sh_n     = rx_sh;
        rsp_data_n  = rsp_data;
        tx_pins_n   = '0;
        tx_fetch_n  = 1'b0;
        rsp_valid_n = 1'b0;
        wr_done_n   = 1'b0;
        unique case (state)
            IDLE: begin
                if (req_valid) begin
                    state_n      = TX_START;
                    tx_sh_n      = req_addr;
                    wdata_q_n    = req_wdata;
                    write_q_n    = req_write;
                    fetch_q_n    = req_fetch & ~req_write;
                    tx_pins_n[0] = 1'b1;
                    tx_pins_n[1] = req_write;
                    tx_fetch_n   = req_fetch & ~req_write;
                end
            end
            TX_START: begin
                state_n    = TX_ADDR;
                cnt_n      = '0;
                tx_pins_n  = tx_sh[IO_BITS-1:0];
                tx_sh_n    = tx_sh >> IO_BITS;
                tx_fetch_n = fetch_q;
            end
            TX_ADDR: begin
                if (cnt == LAST) begin
                    cnt_n = '0;
                    if (write_q) begin
                        state_n   = TX_DATA;
                        tx_pins_n = wdata_q[IO_BITS-1:0];
                        tx_sh_n   = wdata_q >> IO_BITS;
                    end else begin
                        state_n = RX_WAIT;
                    end
                end else begin
                    cnt_n      = cnt + CW'(1);
                    tx_pins_n  = tx_sh[IO_BITS-1:0];
                    tx_sh_n    = tx_sh >> IO_BITS;
                    tx_fetch_n = fetch_q;
                end
            end
            TX_DATA: begin
                if (cnt == LAST) begin
                    state_n   = IDLE;
                    cnt_n     = '0;
                    wr_done_n = 1'b1;
                end else begin
                    cnt_n     = cnt + CW'(1);
                    tx_pins_n = tx_sh[IO_BITS-1:0];
                    tx_sh_n   = tx_sh >> IO_BITS;
                end
            end
            RX_WAIT: begin
                if (rx_pins[0]) begin
                    state_n = RX_DATA;
                    cnt_n   = '0;
                end
            end
            RX_DATA: begin
                rx_sh_n = rx_cat[DATA_BITS+IO_BITS-1:IO_BITS];
                if (cnt == LAST) begin
                    state_n     = IDLE;
                    cnt_n       = '0;
                    rsp_data_n  = rx_cat[DATA_BITS+IO_BITS-1:IO_BITS];
                    rsp_valid_n = 1'b1;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            tx_sh     <= '0;
            wdata_q   <= '0;
            write_q   <= 1'b0;
            fetch_q   <= 1'b0;
            rx_sh     <= '0;
            rsp_data  <= '0;
            tx_pins   <= '0;
            tx_fetch  <= 1'b0;
            rsp_valid <= 1'b0;
            wr_done   <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            tx_sh     <= tx_sh_n;
            wdata_q   <= wdata_q_n;
            write_q   <= write_q_n;
            fetch_q   <= fetch_q_n;
            rx_sh     <= rx_sh_n;
            rsp_data  <= rsp_data_n;
            tx_pins   <= tx_pins_n;
            tx_fetch  <= tx_fetch_n;
            rsp_valid <= rsp_valid_n;
            wr_done   <= wr_done_n;
        end
    end
endmodule

// File: tb/tb_cpu_serial_port.sv
// Scoreboard bench for cpu_serial_port: expected tx chunks and read data are
// queued when requests are issued and compared as the port produces them.
module tb_cpu_serial_port;
    localparam int IO     = 2;
    localparam int D      = 16;
    localparam int NCHUNK = D / IO;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req_valid, req_ready, req_write, req_fetch;
    logic [D-1:0]  req_addr, req_wdata;
    logic          rsp_valid;
    logic [D-1:0]  rsp_data;
    logic          wr_done;
    logic [IO-1:0] tx_pins;
    logic          tx_fetch;
    logic [IO-1:0] rx_pins;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [IO-1:0] pins;
        logic          fetch;
    } tx_exp_t;

    tx_exp_t      txq[$];
    logic [D-1:0] rspq[$];

    cpu_serial_port #(.IO_BITS(IO), .DATA_BITS(D)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_fetch(req_fetch),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .wr_done(wr_done),
        .tx_pins(tx_pins), .tx_fetch(tx_fetch), .rx_pins(rx_pins)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [IO-1:0] chunk_of(input logic [D-1:0] w, input int k);
        logic [D-1:0] t;
        t = w >> (k * IO);
        return t[IO-1:0];
    endfunction

    // Drive a request and queue the expected frame; the accept edge is the next tick.
    task automatic issue(input logic w, input logic f, input logic [D-1:0] a, input logic [D-1:0] d);
        tx_exp_t e;
        logic    fx;
        fx = f & ~w;
        req_valid = 1'b1;
        req_write = w;
        req_fetch = f;
        req_addr  = a;
        req_wdata = d;
        e.pins = w ? IO'(3) : IO'(1);
        e.fetch = fx;
        txq.push_back(e);
        for (int k = 0; k < NCHUNK; k++) begin
            e.pins = chunk_of(a, k); e.fetch = fx; txq.push_back(e);
        end
        if (w) begin
            for (int k = 0; k < NCHUNK; k++) begin
                e.pins = chunk_of(d, k); e.fetch = 1'b0; txq.push_back(e);
            end
        end
    endtask

    // Compare every queued tx chunk; called while the start chunk is on the pins.
    task automatic check_tx(input logic noise);
        tx_exp_t e;
        int      idx = 0;
        while (txq.size() > 0) begin
            e = txq.pop_front();
            rx_pins = noise ? IO'(1) : IO'(0);
            checks++;
            if (tx_pins !== e.pins) begin
                failures++;
                $display("FAIL tx_pins[%0d]: got %h expected %h", idx, tx_pins, e.pins);
            end
            checks++;
            if (tx_fetch !== e.fetch) begin
                failures++;
                $display("FAIL tx_fetch[%0d]: got %b expected %b", idx, tx_fetch, e.fetch);
            end
            checks++;
            if (req_ready !== 1'b0 || wr_done !== 1'b0 || rsp_valid !== 1'b0) begin
                failures++;
                $display("FAIL busy_flags[%0d]: got ready=%b wr_done=%b rsp_valid=%b expected 0 0 0",
                         idx, req_ready, wr_done, rsp_valid);
            end
            idx++;
            tick();
        end
        rx_pins = '0;
    endtask

    task automatic check_wr_done();
        checks++;
        if (wr_done !== 1'b1 || req_ready !== 1'b1 || tx_pins !== '0) begin
            failures++;
            $display("FAIL wr_done_cycle: got wr_done=%b ready=%b tx=%h expected 1 1 0", wr_done, req_ready, tx_pins);
        end
    endtask

    task automatic rx_respond(input logic [D-1:0] data, input int delay);
        logic [D-1:0] exp_d;
        for (int i = 0; i < delay; i++) begin
            checks++;
            if (rsp_valid !== 1'b0 || tx_pins !== '0 || req_ready !== 1'b0) begin
                failures++;
                $display("FAIL rx_wait[%0d]: got rsp_valid=%b tx=%h ready=%b expected 0 0 0", i, rsp_valid, tx_pins, req_ready);
            end
            tick();
        end
        rx_pins = IO'(1);
        rspq.push_back(data);
        for (int k = 0; k < NCHUNK; k++) begin
            tick();
            checks++;
            if (rsp_valid !== 1'b0) begin
                failures++;
                $display("FAIL rsp_early[%0d]: got rsp_valid=%b expected 0", k + 1, rsp_valid);
            end
            rx_pins = chunk_of(data, k);
        end
        tick();
        rx_pins = '0;
        exp_d = rspq.pop_front();
        checks++;
        if (rsp_valid !== 1'b1) begin
            failures++;
            $display("FAIL rsp_latency: got rsp_valid=%b expected 1 at edge %0d", rsp_valid, NCHUNK + 1);
        end
        checks++;
        if (rsp_data !== exp_d) begin
            failures++;
            $display("FAIL rsp_data: got %h expected %h", rsp_data, exp_d);
        end
        checks++;
        if (req_ready !== 1'b1) begin
            failures++;
            $display("FAIL rsp_ready: got %b expected 1", req_ready);
        end
        tick();
        checks++;
        if (rsp_valid !== 1'b0 || rsp_data !== exp_d) begin
            failures++;
            $display("FAIL rsp_pulse_hold: got rsp_valid=%b data=%h expected 0 %h", rsp_valid, rsp_data, exp_d);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        checks++;
        if (req_ready !== 1'b1 || tx_pins !== '0 || tx_fetch !== 1'b0 ||
            rsp_valid !== 1'b0 || wr_done !== 1'b0 || rsp_data !== '0) begin
            failures++;
            $display("FAIL reset_state: got ready=%b tx=%h fetch=%b rv=%b wd=%b data=%h expected 1 0 0 0 0 0",
                     req_ready, tx_pins, tx_fetch, rsp_valid, wr_done, rsp_data);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_read_fetch();
        issue(1'b0, 1'b1, 16'h1234, 16'h0000);
        tick();
        req_valid = 1'b0;
        check_tx(1'b0);
        rx_respond(16'hBEEF, 0);
    endtask

    task automatic test_write(input logic f, input logic [D-1:0] a, input logic [D-1:0] d);
        issue(1'b1, f, a, d);
        tick();
        req_valid = 1'b0;
        check_tx(1'b0);
        check_wr_done();
        tick();
        checks++;
        if (wr_done !== 1'b0) begin
            failures++;
            $display("FAIL wr_done_pulse: got %b expected 0", wr_done);
        end
    endtask

    task automatic test_read_delayed_noise();
        issue(1'b0, 1'b0, 16'h5A3C, 16'hFFFF);
        tick();
        req_valid = 1'b0;
        check_tx(1'b1);
        rx_respond(16'h1E2D, 20);
    endtask

    task automatic test_back_to_back();
        issue(1'b1, 1'b0, 16'hC0DE, 16'h3F81);
        tick();
        // Hold valid high and swap in the read request while the write is busy.
        req_write = 1'b0;
        req_fetch = 1'b1;
        req_addr  = 16'h7E42;
        req_wdata = 16'h0000;
        check_tx(1'b0);
        check_wr_done();
        issue(1'b0, 1'b1, 16'h7E42, 16'h0000);
        tick();
        req_valid = 1'b0;
        check_tx(1'b0);
        rx_respond(16'h9137, 3);
    endtask

    task automatic test_reset_mid_frame();
        issue(1'b1, 1'b0, 16'hABCD, 16'h1357);
        tick();
        req_valid = 1'b0;
        // Start chunk then address chunks 0..2; chunk 3 is on the pins afterwards.
        for (int i = 0; i < 4; i++) begin
            void'(txq.pop_front());
            tick();
        end
        checks++;
        if (tx_pins !== chunk_of(16'hABCD, 3)) begin
            failures++;
            $display("FAIL mid_chunk3: got %h expected %h", tx_pins, chunk_of(16'hABCD, 3));
        end
        txq.delete();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        checks++;
        if (tx_pins !== '0 || req_ready !== 1'b1 || wr_done !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset: got tx=%h ready=%b wr_done=%b expected 0 1 0", tx_pins, req_ready, wr_done);
        end
        for (int i = 0; i < 20; i++) begin
            tick();
            checks++;
            if (wr_done !== 1'b0 || tx_pins !== '0) begin
                failures++;
                $display("FAIL mid_abort[%0d]: got wr_done=%b tx=%h expected 0 0", i, wr_done, tx_pins);
            end
        end
        issue(1'b0, 1'b0, 16'h0F0F, 16'h0000);
        tick();
        req_valid = 1'b0;
        check_tx(1'b0);
        rx_respond(16'hCAFE, 1);
    endtask

    initial begin
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_fetch = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        rx_pins   = '0;
        test_reset();
        test_read_fetch();
        test_write(1'b0, 16'h00FF, 16'hA5C3);
        test_write(1'b1, 16'h8421, 16'h6B2D);
        test_read_delayed_noise();
        test_back_to_back();
        test_reset_mid_frame();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
